// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a shared-memory multicycle RV32I datapath
// (PC, IR, OldPC, ALUOut and Data registers). Each instruction is sequenced
// through fetch, decode, execute, memory and writeback cycles. Memory
// accesses wait on mem_ready, and branches gate PCWrite on the ALU flags.
// Encodings the controller does not support raise a one-cycle Illegal pulse.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   op/funct3/funct7b5 : instruction fields taken from IR
//   Zero/Lt/Ltu     : ALU comparison flags used for branch resolution
//   mem_ready       : memory access completes this cycle
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite : datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl : datapath mux/op selects
//   Illegal         : one-cycle flag when an illegal encoding is decoded
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALUCTRL_W     = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int EXT_BRANCH    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic HS_ON  = (MEM_HANDSHAKE != 0);
    localparam logic EXT_ON = (EXT_BRANCH != 0);

    // ALU operation for R-type / I-type arithmetic. Subtract only exists for
    // register-register ops; on I-type, funct7b5 is an immediate bit.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       op5,
                                              input logic       f7b5);
        case (f3)
            3'b000:  alu_decode = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // Immediate format implied by the opcode.
    function automatic logic [2:0] imm_decode(input logic [6:0] opc);
        case (opc)
            OP_STORE:  imm_decode = 3'b001;
            OP_BRANCH: imm_decode = 3'b010;
            OP_JAL:    imm_decode = 3'b011;
            OP_LUI:    imm_decode = 3'b100;
            default:   imm_decode = 3'b000;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    state_t      dec_next_s;
    state_t      out_state_s;
    logic        ready_s;
    logic        br_raw_taken_s;
    logic        br_raw_ill_s;
    logic        br_illegal_s;
    logic        br_taken_s;
    logic [2:0]  imm_s;
    logic [3:0]  alu_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        illegal_s;

    assign ready_s = mem_ready | ~HS_ON;
    assign imm_s   = imm_decode(op);

    // Branch condition table; funct3 010/011 are not branches.
    always_comb begin
        br_raw_taken_s = 1'b0;
        br_raw_ill_s   = 1'b0;
        case (funct3)
            3'b000:  br_raw_taken_s = Zero;
            3'b001:  br_raw_taken_s = ~Zero;
            3'b100:  br_raw_taken_s = Lt;
            3'b101:  br_raw_taken_s = ~Lt;
            3'b110:  br_raw_taken_s = Ltu;
            3'b111:  br_raw_taken_s = ~Ltu;
            default: br_raw_ill_s   = 1'b1;
        endcase
    end

    // Without the extended branch set, only beq/bne (funct3[2]==0) are legal.
    assign br_illegal_s = br_raw_ill_s | (~EXT_ON & funct3[2]);
    assign br_taken_s   = br_raw_taken_s & ~br_illegal_s;

    // Opcode dispatch out of DECODE; unknown opcodes return to FETCH.
    always_comb begin
        dec_next_s = S_FETCH;
        case (op)
            OP_LOAD:   dec_next_s = S_MEMADR;
            OP_STORE:  dec_next_s = S_MEMADR;
            OP_RTYPE:  dec_next_s = S_EXECR;
            OP_ITYPE:  dec_next_s = S_EXECI;
            OP_JAL:    dec_next_s = S_JAL;
            OP_JALR:   dec_next_s = S_JALR;
            OP_BRANCH: dec_next_s = S_BRANCH;
            OP_LUI:    dec_next_s = S_LUI;
            default:   dec_next_s = S_FETCH;
        endcase
    end

    // Next-state logic; mem_ready only matters in the three memory states.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:    state_next_s = ready_s ? S_DECODE : S_FETCH;
            S_DECODE:   state_next_s = dec_next_s;
            S_MEMADR:   state_next_s = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next_s = ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next_s = S_FETCH;
            S_MEMWRITE: state_next_s = ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next_s = S_ALUWB;
            S_EXECI:    state_next_s = S_ALUWB;
            S_ALUWB:    state_next_s = S_FETCH;
            S_BRANCH:   state_next_s = S_FETCH;
            S_JALR:     state_next_s = S_JAL;
            S_JAL:      state_next_s = S_ALUWB;
            S_LUI:      state_next_s = S_FETCH;
            default:    state_next_s = S_FETCH;
        endcase
    end

    // State register; reset abandons any partially executed instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // While reset is high the outputs present FETCH values regardless of state.
    assign out_state_s = reset ? S_FETCH : state_r;

    // Moore output decode, plus the flag/handshake gating on write enables.
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 3'b000;
        alu_s       = ALU_ADD;
        case (out_state_s)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = ready_s;
                pc_write_s = ready_s;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                ImmSrc    = imm_s;
                illegal_s = (dec_next_s == S_FETCH);
            end
            S_MEMADR: begin
                // Keep the op-derived format so stores get their S immediate.
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_s;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_s   = alu_decode(funct3, op[5], funct7b5);
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_s;
                alu_s   = alu_decode(funct3, op[5], funct7b5);
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_s      = ALU_SUB;
                pc_write_s = br_taken_s;
                illegal_s  = br_illegal_s;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_s;
            end
            S_JAL: begin
                // ALU computes OldPC+4 while PC loads the target from ALUOut.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
            end
            S_LUI: begin
                ImmSrc      = 3'b100;
                ResultSrc   = 2'b11;
                reg_write_s = 1'b1;
            end
            default: begin
                alu_s = ALU_ADD;
            end
        endcase
    end

    assign ALUControl = ALUCTRL_W'(alu_s);
    assign PCWrite    = pc_write_s  & ~reset;
    assign IRWrite    = ir_write_s  & ~reset;
    assign MemWrite   = mem_write_s & ~reset;
    assign RegWrite   = reg_write_s & ~reset;
    assign Illegal    = illegal_s   & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Lt, Ltu;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [18:0] exp_q[$];
    logic [18:0] mask_q[$];
    string       tag_q[$];

    localparam logic [18:0] M_ALL   = 19'h7FFFF;
    localparam logic [18:0] M_NOIMM = 19'h7FF1F;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // Expected output vector: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
    function automatic logic [18:0] ev(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu, input logic ill);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [18:0] v_fetch(input logic r);
        return ev(r, 1'b0, r, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_decode(input logic [2:0] imm, input logic ill);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'd0, ill);
    endfunction
    function automatic logic [18:0] v_memadr();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_memread();
        return ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_memwb();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_memwrite();
        return ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_execr(input logic [3:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 1'b0);
    endfunction
    function automatic logic [18:0] v_execi(input logic [3:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 1'b0);
    endfunction
    function automatic logic [18:0] v_aluwb();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_branch(input logic taken, input logic ill);
        return ev(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, ill);
    endfunction
    function automatic logic [18:0] v_jalr();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_jal();
        return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [18:0] v_lui();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b100, 4'd0, 1'b0);
    endfunction

    // One clock cycle: drive inputs after the falling edge, queue the
    // expectation, then pop and compare once the outputs have settled.
    task automatic step(input logic rst, input logic rdy, input logic [18:0] exp,
                        input logic [18:0] mask, input string tag);
        logic [18:0] obs;
        logic [18:0] e;
        logic [18:0] m;
        string       t;
        @(negedge clk);
        reset     = rst;
        mem_ready = rdy;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        tag_q.push_back(tag);
        #1;
        obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, Illegal};
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert ((obs & m) === (e & m)) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", t, obs & m, e & m);
        end
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
        instr(7'b0110011, 3'b000, 1'b0);

        // Reset held three cycles: FETCH values with every write enable low.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, v_fetch(1'b0), M_ALL, "reset");

        // add x3,x1,x2 (mem_ready low in DECODE must not stall it)
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "add_fetch");
        step(1'b0, 1'b0, v_decode(3'b000, 1'b0), M_ALL, "add_decode");
        step(1'b0, 1'b1, v_execr(4'd0),   M_ALL,   "add_execr");
        step(1'b0, 1'b1, v_aluwb(),       M_ALL,   "add_aluwb");

        // sub (R-type funct7b5=1)
        instr(7'b0110011, 3'b000, 1'b1);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "sub_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "sub_decode");
        step(1'b0, 1'b1, v_execr(4'd1),   M_ALL,   "sub_execr");
        step(1'b0, 1'b1, v_aluwb(),       M_ALL,   "sub_aluwb");

        // addi with immediate bit 30 set stays add; srai decodes to sra
        instr(7'b0010011, 3'b000, 1'b1);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "addi_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "addi_decode");
        step(1'b0, 1'b1, v_execi(4'd0),   M_NOIMM, "addi_execi");
        step(1'b0, 1'b1, v_aluwb(),       M_ALL,   "addi_aluwb");
        instr(7'b0010011, 3'b101, 1'b1);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "srai_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "srai_decode");
        step(1'b0, 1'b1, v_execi(4'd9),   M_NOIMM, "srai_execi");
        step(1'b0, 1'b1, v_aluwb(),       M_ALL,   "srai_aluwb");

        // lw with 2 wait cycles in FETCH and 2 in MEMREAD: 9 cycles
        instr(7'b0000011, 3'b010, 1'b0);
        step(1'b0, 1'b0, v_fetch(1'b0),   M_ALL,   "lw_fetch_wait1");
        step(1'b0, 1'b0, v_fetch(1'b0),   M_ALL,   "lw_fetch_wait2");
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "lw_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "lw_decode");
        step(1'b0, 1'b1, v_memadr(),      M_NOIMM, "lw_memadr");
        step(1'b0, 1'b0, v_memread(),     M_ALL,   "lw_memread_wait1");
        step(1'b0, 1'b0, v_memread(),     M_ALL,   "lw_memread_wait2");
        step(1'b0, 1'b1, v_memread(),     M_ALL,   "lw_memread");
        step(1'b0, 1'b1, v_memwb(),       M_ALL,   "lw_memwb");

        // sw with MemWrite held over three MEMWRITE cycles
        instr(7'b0100011, 3'b010, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "sw_fetch");
        step(1'b0, 1'b1, v_decode(3'b001, 1'b0), M_ALL, "sw_decode");
        step(1'b0, 1'b1, v_memadr(),      M_NOIMM, "sw_memadr");
        step(1'b0, 1'b0, v_memwrite(),    M_ALL,   "sw_memwrite_wait1");
        step(1'b0, 1'b0, v_memwrite(),    M_ALL,   "sw_memwrite_wait2");
        step(1'b0, 1'b1, v_memwrite(),    M_ALL,   "sw_memwrite");

        // Branches: blt taken, bgeu not taken, beq taken, funct3=010 illegal
        instr(7'b1100011, 3'b100, 1'b0); Lt = 1'b1;
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "blt_fetch");
        step(1'b0, 1'b1, v_decode(3'b010, 1'b0), M_ALL, "blt_decode");
        step(1'b0, 1'b1, v_branch(1'b1, 1'b0), M_ALL, "blt_branch");
        instr(7'b1100011, 3'b111, 1'b0); Lt = 1'b0; Ltu = 1'b1;
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "bgeu_fetch");
        step(1'b0, 1'b1, v_decode(3'b010, 1'b0), M_ALL, "bgeu_decode");
        step(1'b0, 1'b1, v_branch(1'b0, 1'b0), M_ALL, "bgeu_branch");
        instr(7'b1100011, 3'b000, 1'b0); Ltu = 1'b0; Zero = 1'b1;
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "beq_fetch");
        step(1'b0, 1'b1, v_decode(3'b010, 1'b0), M_ALL, "beq_decode");
        step(1'b0, 1'b1, v_branch(1'b1, 1'b0), M_ALL, "beq_branch");
        instr(7'b1100011, 3'b010, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "br010_fetch");
        step(1'b0, 1'b1, v_decode(3'b010, 1'b0), M_ALL, "br010_decode");
        step(1'b0, 1'b1, v_branch(1'b0, 1'b1), M_ALL, "br010_branch");
        Zero = 1'b0;

        // jalr: 5 cycles
        instr(7'b1100111, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "jalr_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "jalr_decode");
        step(1'b0, 1'b1, v_jalr(),        M_NOIMM, "jalr_jalr");
        step(1'b0, 1'b1, v_jal(),         M_ALL,   "jalr_jal");
        step(1'b0, 1'b1, v_aluwb(),       M_ALL,   "jalr_aluwb");

        // jal: 4 cycles, mem_ready ignored outside memory states
        instr(7'b1101111, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "jal_fetch");
        step(1'b0, 1'b0, v_decode(3'b011, 1'b0), M_ALL, "jal_decode");
        step(1'b0, 1'b0, v_jal(),         M_ALL,   "jal_jal");
        step(1'b0, 1'b0, v_aluwb(),       M_ALL,   "jal_aluwb");

        // lui: 3 cycles
        instr(7'b0110111, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "lui_fetch");
        step(1'b0, 1'b1, v_decode(3'b100, 1'b0), M_ALL, "lui_decode");
        step(1'b0, 1'b1, v_lui(),         M_ALL,   "lui_lui");

        // Reset in the middle of a stalled store
        instr(7'b0100011, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "swr_fetch");
        step(1'b0, 1'b1, v_decode(3'b001, 1'b0), M_ALL, "swr_decode");
        step(1'b0, 1'b1, v_memadr(),      M_NOIMM, "swr_memadr");
        step(1'b0, 1'b0, v_memwrite(),    M_ALL,   "swr_memwrite");
        step(1'b1, 1'b0, v_fetch(1'b0),   M_ALL,   "swr_reset");
        step(1'b0, 1'b0, v_fetch(1'b0),   M_ALL,   "swr_after_reset_fetch");

        // Illegal opcode: one Illegal pulse in DECODE, then back to FETCH
        instr(7'b1111111, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "ill_fetch");
        step(1'b0, 1'b1, v_decode(3'b000, 1'b1), M_ALL, "ill_decode");
        step(1'b0, 1'b1, v_fetch(1'b1),   M_ALL,   "ill_back_fetch");
        instr(7'b0110011, 3'b000, 1'b0);
        step(1'b0, 1'b1, v_decode(3'b000, 1'b0), M_ALL, "ill_next_decode");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
